// File: rtl/alu_regfile_signex.sv
// Integer execution core: 32x32 register file with write-through bypass,
// 16->32 sign extender and a combinational ALU with zero flag.
module alu_regfile_signex #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [4:0]        wa,
    input  logic              we,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] signimm,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [3:0]        alu_f,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zf
);

    typedef enum logic [3:0] {
        F_AND  = 4'b0000,
        F_OR   = 4'b0001,
        F_ADD  = 4'b0010,
        F_XOR  = 4'b0011,
        F_NOR  = 4'b0100,
        F_SLL  = 4'b0101,
        F_SUB  = 4'b0110,
        F_SLT  = 4'b0111,
        F_SLTU = 4'b1000,
        F_SRL  = 4'b1001,
        F_SRA  = 4'b1010,
        F_LUI  = 4'b1011
    } alu_fn_e;

    logic [REG_CNT-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                           wr_en;
    logic                           byp1, byp2;

    assign wr_en = we && (wa != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wa] = wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs_q <= '0;
        else          regs_q <= regs_d;
    end

    // Bypass lets writeback and decode share a cycle; it is off during reset
    // so the cleared file is what both ports see.
    assign byp1 = reset_n && wr_en && (wa == ra1);
    assign byp2 = reset_n && wr_en && (wa == ra2);
    assign rd1  = byp1 ? wd : regs_q[ra1];
    assign rd2  = byp2 ? wd : regs_q[ra2];

    assign signimm = {{(DATA_W-16){imm[15]}}, imm};

    logic [4:0]        shamt;
    logic [DATA_W-1:0] sra_y;

    assign shamt = alu_a[4:0];
    assign sra_y = $signed(alu_b) >>> shamt;

    always_comb begin
        alu_y = '0;
        case (alu_f)
            F_AND:  alu_y = alu_a & alu_b;
            F_OR:   alu_y = alu_a | alu_b;
            F_ADD:  alu_y = alu_a + alu_b;
            F_XOR:  alu_y = alu_a ^ alu_b;
            F_NOR:  alu_y = ~(alu_a | alu_b);
            F_SLL:  alu_y = alu_b << shamt;
            F_SUB:  alu_y = alu_a - alu_b;
            F_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            F_SLTU: alu_y = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
            F_SRL:  alu_y = alu_b >> shamt;
            F_SRA:  alu_y = sra_y;
            F_LUI:  alu_y = {alu_b[15:0], 16'h0000};
            default: alu_y = '0;
        endcase
    end

    assign alu_zf = (alu_y == '0);

endmodule

// File: tb/tb_alu_regfile_signex.sv
// Directed bench for alu_regfile_signex: register file, bypass, reset,
// sign extension and every ALU function against hand-computed values.
module tb_alu_regfile_signex;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd1, rd2, signimm, alu_y;
    logic [15:0] imm = '0;
    logic [31:0] alu_a = '0, alu_b = '0;
    logic [3:0]  alu_f = '0;
    logic        alu_zf;

    int checks = 0;
    int errors = 0;

    alu_regfile_signex dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (ra1),
        .ra2     (ra2),
        .wa      (wa),
        .we      (we),
        .wd      (wd),
        .rd1     (rd1),
        .rd2     (rd2),
        .imm     (imm),
        .signimm (signimm),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_f   (alu_f),
        .alu_y   (alu_y),
        .alu_zf  (alu_zf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] y, input logic zf);
        alu_f = f; alu_a = a; alu_b = b;
        #1;
        chk({tag, "_y"}, alu_y, y);
        chk({tag, "_zf"}, {31'd0, alu_zf}, {31'd0, zf});
    endtask

    task automatic sx_vec(input logic [15:0] i, input logic [31:0] exp);
        imm = i;
        #1;
        chk("signimm", signimm, exp);
    endtask

    initial begin
        // Reset pulse between clock edges, then scan the whole file.
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd1, 32'h0);
            chk("rst_rd2", rd2, 32'h0);
        end

        // Write then read back on both ports.
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        chk("wr5_rd1", rd1, 32'hDEADBEEF);
        chk("wr5_rd2", rd2, 32'hDEADBEEF);

        // Register 0 ignores writes, including through the bypass.
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd5;
        #1;
        chk("r0_byp", rd1, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("r0_rd1", rd1, 32'h0);
        chk("r5_keep", rd2, 32'hDEADBEEF);

        // Bypass before the edge, registered value after it.
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra1 = 5'd7; ra2 = 5'd3;
        #1;
        chk("byp_rd1", rd1, 32'h12345678);
        chk("byp_rd2", rd2, 32'h0);
        @(posedge clk);
        #1;
        chk("wr7_rd1", rd1, 32'h12345678);

        // Async reset with a write still pending: bypass off, file cleared.
        reset_n = 1'b0;
        ra2 = 5'd5;
        #1;
        chk("rst_byp_rd1", rd1, 32'h0);
        chk("rst_r5_rd2", rd2, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_rd1", rd1, 32'h0);
        @(negedge clk);
        we = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_rd1", rd1, 32'h0);

        // Sign extender.
        sx_vec(16'h7FFF, 32'h00007FFF);
        sx_vec(16'h8000, 32'hFFFF8000);
        sx_vec(16'hFFFF, 32'hFFFFFFFF);
        sx_vec(16'h0000, 32'h00000000);

        // ALU.
        alu_vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1);
        alu_vec("sub_neg",  4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0);
        alu_vec("slt",      4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
        alu_vec("slt_f",    4'b0111, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1);
        alu_vec("sltu",     4'b1000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1);
        alu_vec("sltu_t",   4'b1000, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0);
        alu_vec("sub_zero", 4'b0110, 32'd9,        32'd9,        32'h0,        1'b1);
        alu_vec("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        alu_vec("or",       4'b0001, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0);
        alu_vec("xor",      4'b0011, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0);
        alu_vec("nor",      4'b0100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
        alu_vec("sll",      4'b0101, 32'd4,        32'h1,        32'h10,       1'b0);
        alu_vec("sll_hi_a", 4'b0101, 32'h24,       32'h1,        32'h10,       1'b0);
        alu_vec("sra",      4'b1010, 32'd4,        32'h80000000, 32'hF8000000, 1'b0);
        alu_vec("srl",      4'b1001, 32'd4,        32'h80000000, 32'h08000000, 1'b0);
        alu_vec("lui",      4'b1011, 32'h0,        32'h1234,     32'h12340000, 1'b0);
        alu_vec("f1100",    4'b1100, 32'h5,        32'h3,        32'h0,        1'b1);
        alu_vec("f1111",    4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1);
    end

endmodule

// File: doc/alu_regfile_signex.md
Name: alu_regfile_signex

Overview:
Combined integer execution core for the 5-stage MIPS pipeline. It bundles three independent sub-functions:
- a 32x32-bit register file with two combinational read ports and one synchronous write port;
- a 16-to-32-bit sign extender;
- a 32-bit combinational ALU with zero flag.

Decode reads operands and sign-extends immediates here. Execute uses the ALU. Writeback drives the write port.

Parameters:
- DATA_W, 32, datapath width (fixed at 32; other values unsupported).
- REG_CNT, 32, number of architectural registers (address width 5).

Ports:
- clk  in  1  rising-edge clock for register writes.
- reset_n  in  1  asynchronous active-low reset; clears all registers.
- ra1  in  5  read address port 1 (rs).
- ra2  in  5  read address port 2 (rt).
- wa  in  5  write address.
- we  in  1  write enable.
- wd  in  32  write data.
- rd1  out  32  read data port 1.
- rd2  out  32  read data port 2.
- imm  in  16  immediate field.
- signimm  out  32  sign-extended immediate.
- alu_a  in  32  ALU operand A.
- alu_b  in  32  ALU operand B.
- alu_f  in  4  ALU function select.
- alu_y  out  32  ALU result.
- alu_zf  out  1  1 when alu_y == 0.

Behaviour:
Register file:
- Registers 0..31 cleared to 0 asynchronously while reset_n=0, independent of clk.
- Write occurs on rising clk when we=1, reset_n=1 and wa!=0. Writes to register 0 are ignored; register 0 always reads 0.
- Reads are combinational: rd1=reg[ra1], rd2=reg[ra2].
- Write-through bypass: if we=1, wa!=0 and wa==ra1 (or ra2), the corresponding rd port returns wd in the same cycle. This lets writeback and decode share a cycle without a hazard.
- Both ports may read the same address simultaneously.
- A reset asserted mid-cycle overrides any pending write.

Sign extender:
- Purely combinational: signimm = {16{imm[15]}, imm}.

ALU:
- Purely combinational; all arithmetic is modulo 2^32; overflow and carry are not reported.
- alu_f encoding:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b
  - 0011 XOR: a ^ b
  - 0100 NOR: ~(a | b)
  - 0101 SLL: b << a[4:0]
  - 0110 SUB: a - b
  - 0111 SLT: 1 if signed(a) < signed(b), else 0 (zero-extended)
  - 1000 SLTU: 1 if unsigned(a) < unsigned(b), else 0
  - 1001 SRL: b >> a[4:0], logical
  - 1010 SRA: b >>> a[4:0], arithmetic
  - 1011 LUI: {b[15:0], 16'h0}
  - 1100..1111: alu_y = 0
- alu_zf = (alu_y == 32'h0) for every function, including the unused codes (zf=1 there).
- Shift amounts use only a[4:0]; a[31:5] is ignored.

Latency:
- Reads, sign extension and ALU: 0 cycles.
- Register write: visible on the registered path the cycle after the clock edge, and immediately through the bypass.

Outputs under reset:
- rd1/rd2 = 0, except when the bypass is active (which still requires reset_n=1 for the write itself; bypass is disabled while reset_n=0).
- signimm and alu_y continue to follow their inputs.

Test Plan:
- Reset then read: pulse reset_n low with no clk edge; read all 32 addresses -> rd1=rd2=0 for every address.
- Write/readback: we=1, wa=5, wd=0xDEADBEEF, rising edge; then ra1=ra2=5 -> both 0xDEADBEEF. Write wa=0, wd=0xFFFFFFFF -> reg 0 still reads 0.
- Bypass and reset: set we=1, wa=7, wd=0x12345678 with ra1=7 before the edge -> rd1=0x12345678 combinationally. Assert reset_n=0 asynchronously after the write -> rd1=0 immediately.
- Sign extend: imm=0x7FFF -> 0x00007FFF; imm=0x8000 -> 0xFFFF8000; imm=0xFFFF -> 0xFFFFFFFF.
- ALU arithmetic:
  - ADD 0xFFFFFFFF+1 -> y=0, zf=1.
  - SUB 5-7 -> 0xFFFFFFFE, zf=0.
  - SLT a=0xFFFFFFFF, b=1 -> 1.
  - SLTU same operands -> 0.
  - SUB 9-9 -> zf=1.
- ALU logic/shift:
  - AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
  - NOR 0, 0 -> 0xFFFFFFFF.
  - SLL a=4, b=1 -> 0x10.
  - SRA a=4, b=0x80000000 -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - LUI b=0x1234 -> 0x12340000.
  - alu_f=1111 -> y=0, zf=1.
